bt_sync_correlator: RTL and testbench

Receive-side access-code correlator for the Bluetooth baseband, the counterpart of the access-code transmit path that serialises preamble and sync word onto `txbit`. It takes the 1 Mb/s demodulated bit stream (`rxbit`, qualified by a per-bit strobe from the 6 MHz timing) and slides a 64-bit window over it. It counts bit agreements against the programmed sync word and reports a detection when the count reaches `regi_correthreshold` inside a bounded search window. It sits between the demodulator and the receive packet FSM, and is armed once per receive slot or scan window.

---
 rtl/bt_sync_correlator_if.sv | 23 ++
 rtl/bt_sync_correlator.sv | 126 ++++++++++++
 tb/tb_bt_sync_correlator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bt_sync_correlator_if.sv
// Bit-stream, control and result signals of the access-code correlator.
// The master side is the demodulator/packet-FSM pair; the correlator is the slave.
interface bt_sync_correlator_if;
  logic        bit_strobe;
  logic        rxbit;
  logic        search_start;
  logic        search_cancel;
  logic        sync_busy;
  logic        sync_found;
  logic        sync_timeout;
  logic [6:0]  found_corr;
  logic [10:0] found_bitcnt;

  modport master (
    output bit_strobe, rxbit, search_start, search_cancel,
    input  sync_busy, sync_found, sync_timeout, found_corr, found_bitcnt
  );

  modport slave (
    input  bit_strobe, rxbit, search_start, search_cancel,
    output sync_busy, sync_found, sync_timeout, found_corr, found_bitcnt
  );
endinterface

// File: rtl/bt_sync_correlator.sv
// Receive access-code correlator: slides a 64-bit window over the demodulated
// bit stream and flags a sync word hit or a search-window timeout.
module bt_sync_correlator (
  input  logic                       clk_6M,
  input  logic                       rstz,
  input  logic [63:0]                regi_syncword,
  input  logic [5:0]                 regi_correthreshold,
  input  logic [9:0]                 regi_search_win,
  bt_sync_correlator_if.slave        sif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SEARCH
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] sr_q, sr_d;
  logic [10:0] bitcnt_q, bitcnt_d;
  logic        eval_q, eval_d;
  logic        found_q, found_d;
  logic        timeout_q, timeout_d;
  logic [6:0]  found_corr_q, found_corr_d;
  logic [10:0] found_bitcnt_q, found_bitcnt_d;

  logic [63:0] agree;
  logic [6:0]  corr;
  logic [10:0] bitcnt_inc;
  logic [10:0] win_end;

  assign agree      = ~(sr_q ^ regi_syncword);
  assign bitcnt_inc = (&bitcnt_q) ? bitcnt_q : bitcnt_q + 11'd1;
  assign win_end    = 11'd64 + {1'b0, regi_search_win};

  // NOTE: blocking '=' is right here: the loop accumulates within one evaluation
  // of combinational logic, unlike the registers below which must use '<='.
  always_comb begin
    corr = '0;
    for (int i = 0; i < 64; i++) begin
      corr = corr + {6'd0, agree[i]};
    end
  end

  // eval_q marks the cycle after a strobe that left a full window in sr_q;
  // the decision is registered so the pulse lands one cycle later.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d        = state_q;
    sr_d           = sr_q;
    bitcnt_d       = bitcnt_q;
    eval_d         = 1'b0;
    found_d        = 1'b0;
    timeout_d      = 1'b0;
    found_corr_d   = found_corr_q;
    found_bitcnt_d = found_bitcnt_q;

    if (sif.search_cancel) begin
      state_d = S_IDLE;
    end else if (sif.search_start) begin
      state_d        = S_FILL;
      sr_d           = '0;
      bitcnt_d       = '0;
      found_corr_d   = '0;
      found_bitcnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_FILL, S_SEARCH: begin
          if (eval_q) begin
            if (corr >= {1'b0, regi_correthreshold}) begin
              found_d        = 1'b1;
              found_corr_d   = corr;
              found_bitcnt_d = bitcnt_q;
              state_d        = S_IDLE;
            end else if (bitcnt_q == win_end) begin
              timeout_d = 1'b1;
              state_d   = S_IDLE;
            end
          end
          if (state_d != S_IDLE && sif.bit_strobe) begin
            sr_d     = {sif.rxbit, sr_q[63:1]};
            bitcnt_d = bitcnt_inc;
            if (bitcnt_inc >= 11'd64) begin
              state_d = S_SEARCH;
              eval_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sr_q is a shift register rather than a RAM, so it takes the async
  // reset like any other flop and a fresh arm always starts from a known window.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q        <= S_IDLE;
      sr_q           <= '0;
      bitcnt_q       <= '0;
      eval_q         <= 1'b0;
      found_q        <= 1'b0;
      timeout_q      <= 1'b0;
      found_corr_q   <= '0;
      found_bitcnt_q <= '0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      bitcnt_q       <= bitcnt_d;
      eval_q         <= eval_d;
      found_q        <= found_d;
      timeout_q      <= timeout_d;
      found_corr_q   <= found_corr_d;
      found_bitcnt_q <= found_bitcnt_d;
    end
  end

  assign sif.sync_busy    = (state_q != S_IDLE);
  assign sif.sync_found   = found_q;
  assign sif.sync_timeout = timeout_q;
  assign sif.found_corr   = found_corr_q;
  assign sif.found_bitcnt = found_bitcnt_q;

endmodule

// File: tb/tb_bt_sync_correlator.sv
// Directed bench for bt_sync_correlator: a queue-based window model is checked
// every cycle, and literal expectations pin detection position and latency.
module tb_bt_sync_correlator;

  logic        clk_6M = 1'b0;
  logic        rstz;
  logic [63:0] regi_syncword;
  logic [5:0]  regi_correthreshold;
  logic [9:0]  regi_search_win;

  bt_sync_correlator_if sif ();

  bt_sync_correlator dut (
    .clk_6M              (clk_6M),
    .rstz                (rstz),
    .regi_syncword       (regi_syncword),
    .regi_correthreshold (regi_correthreshold),
    .regi_search_win     (regi_search_win),
    .sif                 (sif)
  );

  always #5 clk_6M = ~clk_6M;

  localparam logic [63:0] SYNC = 64'h475c58cc73345e72;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: window of the last 64 bits since arm, oldest first
  bit m_win[$];
  int m_count;
  bit m_busy, m_found, m_timeout;
  bit m_pend;
  int m_pcorr, m_pn;
  int m_fcorr, m_fcnt;

  // observation bookkeeping
  int n_strobes;
  int tas;
  bit seen_found, seen_timeout, seen_busy, to_busy;
  int found_at, found_lat, to_at, to_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int window_corr();
    int c = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_win[i] == regi_syncword[i]) c++;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_win.delete();
    m_count = 0; m_busy = 0; m_found = 0; m_timeout = 0;
    m_pend = 0; m_pcorr = 0; m_pn = 0; m_fcorr = 0; m_fcnt = 0;
  endtask

  // One clock edge as seen by the model, using the inputs held across it.
  task automatic model_step();
    m_found   = 0;
    m_timeout = 0;
    if (!rstz) begin
      model_reset();
      return;
    end
    if (sif.search_cancel) begin
      m_busy = 0;
      m_pend = 0;
    end else if (sif.search_start) begin
      m_busy = 1; m_pend = 0; m_win.delete(); m_count = 0; m_fcorr = 0; m_fcnt = 0;
    end else if (m_busy) begin
      if (m_pend) begin
        m_pend = 0;
        if (m_pcorr >= int'(regi_correthreshold)) begin
          m_found = 1; m_fcorr = m_pcorr; m_fcnt = m_pn; m_busy = 0;
        end else if (m_pn == 64 + int'(regi_search_win)) begin
          m_timeout = 1; m_busy = 0;
        end
      end
      if (m_busy && sif.bit_strobe) begin
        m_win.push_back(sif.rxbit);
        if (m_win.size() > 64) void'(m_win.pop_front());
        if (m_count < 2047) m_count++;
        if (m_count >= 64) begin
          m_pend = 1; m_pcorr = window_corr(); m_pn = m_count;
        end
      end
    end
  endtask

  task automatic tick();
    bit strobe_seen;
    @(posedge clk_6M);
    strobe_seen = sif.bit_strobe && rstz;
    model_step();
    #1;
    tas = strobe_seen ? 1 : tas + 1;
    check("sync_busy",    64'(sif.sync_busy),    64'(m_busy));
    check("sync_found",   64'(sif.sync_found),   64'(m_found));
    check("sync_timeout", 64'(sif.sync_timeout), 64'(m_timeout));
    check("found_corr",   64'(sif.found_corr),   64'(m_fcorr));
    check("found_bitcnt", 64'(sif.found_bitcnt), 64'(m_fcnt));
    if (sif.sync_busy) seen_busy = 1;
    if (sif.sync_found) begin
      seen_found = 1; found_at = n_strobes; found_lat = tas;
    end
    if (sif.sync_timeout) begin
      seen_timeout = 1; to_at = n_strobes; to_lat = tas; to_busy = sif.sync_busy;
    end
  endtask

  task automatic clear_obs();
    n_strobes = 0; seen_found = 0; seen_timeout = 0; seen_busy = 0; to_busy = 1;
    found_at = -1; found_lat = -1; to_at = -1; to_lat = -1;
  endtask

  task automatic arm();
    sif.search_start = 1'b1;
    tick();
    sif.search_start = 1'b0;
    clear_obs();
  endtask

  task automatic send_bit(input bit b);
    sif.bit_strobe = 1'b1;
    sif.rxbit      = b;
    n_strobes++;
    tick();
    sif.bit_strobe = 1'b0;
    sif.rxbit      = 1'($urandom);
    repeat (5) tick();
  endtask

  // Preamble 4'b0101 LSB-first, then the first nbits-4 bits of sw^flips LSB-first.
  task automatic send_frame(input logic [63:0] sw, input logic [63:0] flips, input int nbits);
    logic [3:0]  pre = 4'b0101;
    logic [63:0] data;
    data = sw ^ flips;
    for (int i = 0; i < nbits; i++) begin
      if (i < 4) send_bit(pre[i]);
      else       send_bit(data[i-4]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstz                = 1'b0;
    sif.bit_strobe      = 1'b0;
    sif.rxbit           = 1'b0;
    sif.search_start    = 1'b0;
    sif.search_cancel   = 1'b0;
    regi_syncword       = SYNC;
    regi_correthreshold = 6'd60;
    regi_search_win     = 10'd10;
    model_reset();
    clear_obs();
    tas = 0;
    #2;
    check("reset busy",    64'(sif.sync_busy),    64'd0);
    check("reset found",   64'(sif.sync_found),   64'd0);
    check("reset timeout", 64'(sif.sync_timeout), 64'd0);
    check("reset corr",    64'(sif.found_corr),   64'd0);
    check("reset bitcnt",  64'(sif.found_bitcnt), 64'd0);
    repeat (2) tick();
    rstz = 1'b1;
    repeat (2) tick();

    // exact sync word behind the preamble
    arm();
    send_frame(SYNC, 64'd0, 68);
    repeat (3) tick();
    check("exact found seen",   64'(seen_found), 64'd1);
    check("exact found strobe", 64'(found_at),   64'd68);
    check("exact found latency",64'(found_lat),  64'd2);
    check("exact corr",         64'(sif.found_corr),   64'd64);
    check("exact bitcnt",       64'(sif.found_bitcnt), 64'd68);

    // four bit errors: still detected
    arm();
    send_frame(SYNC, 64'h8000_0100_0002_0008, 68);
    repeat (3) tick();
    check("4err found strobe", 64'(found_at),       64'd68);
    check("4err corr",         64'(sif.found_corr), 64'd60);

    // five bit errors: search window expires at strobe 64+10
    arm();
    send_frame(SYNC, 64'h8000_0100_0202_0008, 68);
    repeat (6) send_bit(1'b0);
    repeat (3) tick();
    check("5err no found",       64'(seen_found),   64'd0);
    check("5err timeout seen",   64'(seen_timeout), 64'd1);
    check("5err timeout strobe", 64'(to_at),        64'd74);
    check("5err timeout latency",64'(to_lat),       64'd2);
    check("5err busy at timeout",64'(to_busy),      64'd0);

    // threshold 0: first full window hits
    regi_correthreshold = 6'd0;
    arm();
    repeat (64) send_bit(1'($urandom));
    repeat (3) tick();
    check("thr0 found strobe", 64'(found_at),         64'd64);
    check("thr0 bitcnt",       64'(sif.found_bitcnt), 64'd64);
    regi_correthreshold = 6'd60;

    // cancel in the cycle after the matching strobe
    arm();
    send_frame(SYNC, 64'd0, 67);
    sif.bit_strobe = 1'b1;
    sif.rxbit      = SYNC[63];
    n_strobes++;
    tick();
    sif.bit_strobe    = 1'b0;
    sif.search_cancel = 1'b1;
    tick();
    sif.search_cancel = 1'b0;
    check("cancel busy next", 64'(sif.sync_busy), 64'd0);
    repeat (5) tick();
    check("cancel no found", 64'(seen_found), 64'd0);

    // start and cancel together: cancel wins
    sif.search_start  = 1'b1;
    sif.search_cancel = 1'b1;
    tick();
    sif.search_start  = 1'b0;
    sif.search_cancel = 1'b0;
    check("start+cancel idle", 64'(sif.sync_busy), 64'd0);
    repeat (2) tick();

    // re-arm at bitcnt 40
    arm();
    repeat (40) send_bit(1'($urandom));
    arm();
    send_frame(SYNC, 64'd0, 68);
    repeat (3) tick();
    check("rearm found strobe", 64'(found_at),         64'd68);
    check("rearm bitcnt",       64'(sif.found_bitcnt), 64'd68);

    // async reset during FILL
    arm();
    repeat (20) send_bit(1'($urandom));
    check("busy before reset", 64'(sif.sync_busy), 64'd1);
    #1 rstz = 1'b0;
    #1;
    check("rst busy",    64'(sif.sync_busy),    64'd0);
    check("rst found",   64'(sif.sync_found),   64'd0);
    check("rst timeout", 64'(sif.sync_timeout), 64'd0);
    check("rst corr",    64'(sif.found_corr),   64'd0);
    check("rst bitcnt",  64'(sif.found_bitcnt), 64'd0);
    model_reset();
    repeat (2) tick();
    rstz = 1'b1;
    clear_obs();
    send_frame(SYNC, 64'd0, 68);
    repeat (3) tick();
    check("post-reset no found", 64'(seen_found), 64'd0);
    check("post-reset no busy",  64'(seen_busy),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
